// File: rtl/data_mem_pkg.sv
// Shared definitions for the pipelined data memory.
// Holds the controller state type, the default geometry constants and the
// request address check used by data_mem_pipe.
package data_mem_pkg;

    // CLEAR zeroes the array one word per cycle; RUN serves requests.
    typedef enum logic [0:0] {
        CLEAR,
        RUN
    } state_e;

    // Default geometry; data_mem_pipe derives its own copies from its parameters.
    localparam int unsigned DATA_W_DFLT = 32;
    localparam int unsigned DEPTH_DFLT  = 64;
    localparam int unsigned BYTES       = DATA_W_DFLT / 8;
    localparam int unsigned OFS_W       = $clog2(BYTES);
    localparam int unsigned IDX_W       = $clog2(DEPTH_DFLT);

    // 1 when the byte address is misaligned or its word index is >= 2**idx_w.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input int unsigned ofs_w,
                                      input int unsigned idx_w);
        logic [31:0] ofs_mask;
        logic        misaligned;
        logic        out_of_range;
        ofs_mask     = (32'd1 << ofs_w) - 32'd1;
        misaligned   = (addr & ofs_mask) != 32'd0;
        out_of_range = (addr >> (ofs_w + idx_w)) != 32'd0;
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/data_mem_rsp_pipe.sv
// Response delay line for data_mem_pipe.
// An RD_LAT-stage shift register of {valid, err, rdata}; every stage is
// synchronously cleared by reset so in-flight responses are dropped.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid/err/rdata    response captured at the acceptance edge
//   out_valid/err/rdata   response RD_LAT edges later
module data_mem_rsp_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_rdata,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_rdata
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] err_q;
    logic [DATA_W-1:0] rdata_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            err_q[0]   <= in_err;
            rdata_q[0] <= in_rdata;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_err   = err_q[RD_LAT-1];
    assign out_rdata = rdata_q[RD_LAT-1];

endmodule

// File: rtl/data_mem_pipe.sv
// Pipelined, byte-addressed data memory with request/response handshake.
// After reset the array is zeroed one word per cycle (busy=1, req_ready=0);
// afterwards one request per cycle is accepted and answered RD_LAT cycles
// later, in order, with no backpressure.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_write, req_addr             1 = write; byte address (word aligned)
//   req_wdata, req_be               write data and per-byte lane enables
//   rsp_valid, rsp_rdata, rsp_err   one-cycle response; rdata 0 on write/error
//   busy                            clear sequence in progress
// DATA_W must be a multiple of 8, DEPTH a power of two >= 2, RD_LAT in 1..4.
module data_mem_pipe
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned DEPTH  = DEPTH_DFLT,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int unsigned LANES    = DATA_W / 8;
    localparam int unsigned OFS_BITS = $clog2(LANES);
    localparam int unsigned IDX_BITS = $clog2(DEPTH);

    state_e              state_q;
    logic [IDX_BITS-1:0] clr_idx_q;
    logic                req_ready_q;
    logic                busy_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                acc;
    logic                err;
    logic [IDX_BITS-1:0] idx;
    logic [DATA_W-1:0]   rd_word;

    // Out-of-range addresses alias onto a valid index here, but err masks
    // both the write and the returned data for them.
    assign acc     = req_valid && req_ready_q;
    assign err     = addr_err(req_addr, OFS_BITS, IDX_BITS);
    assign idx     = req_addr[OFS_BITS +: IDX_BITS];
    assign rd_word = (acc && !req_write && !err) ? mem_q[idx] : '0;

    // Controller: ready/busy are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == IDX_BITS'(DEPTH - 1)) begin
                        state_q     <= RUN;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                RUN: begin
                    state_q     <= RUN;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= CLEAR;
                    clr_idx_q   <= '0;
                    req_ready_q <= 1'b0;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    // Storage: clear writes during CLEAR, byte-lane writes during RUN.
    // No write happens on a reset edge; the clear sequence follows it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_q[clr_idx_q] <= '0;
            end else if (acc && req_write && !err) begin
                for (int i = 0; i < LANES; i++) begin
                    if (req_be[i]) begin
                        mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    data_mem_rsp_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rsp_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (acc),
        .in_err    (acc && err),
        .in_rdata  (rd_word),
        .out_valid (rsp_valid),
        .out_err   (rsp_err),
        .out_rdata (rsp_rdata)
    );

    assign req_ready = req_ready_q;
    assign busy      = busy_q;

endmodule
